calc_engine: RTL and testbench

Parametrised successor to the keypad calculator FSM.
- Accepts decoded keypad events (digits, operators, equals, clear) as one-cycle strobes on the hz100 domain.
- Builds two unsigned decimal operands and executes add, subtract and an iterative multiply, plus an optional iterative divide.
- Presents a display value, sign and error status for the seven-segment layer.
- Sits between the keysync/decoder front end and the display formatting logic.

---
 rtl/calc_pkg.sv | 37 +++
 rtl/calc_if.sv | 23 ++
 rtl/calc_seq_alu.sv | 144 ++++++++++++++
 rtl/calc_engine.sv | 176 +++++++++++++++++
 tb/tb_calc_engine.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types and key codes for the keypad calculator engine.
package calc_pkg;

  typedef enum logic [2:0] {
    StEntry1 = 3'd0,
    StEntry2 = 3'd1,
    StExec   = 3'd2,
    StResult = 3'd3,
    StError  = 3'd4
  } calc_state_t;

  typedef enum logic [2:0] {
    OpNone = 3'd0,
    OpAdd  = 3'd1,
    OpSub  = 3'd2,
    OpMul  = 3'd3,
    OpDiv  = 3'd4
  } calc_op_t;

  localparam logic [4:0] KEY_ADD = 5'd10;
  localparam logic [4:0] KEY_SUB = 5'd11;
  localparam logic [4:0] KEY_MUL = 5'd12;
  localparam logic [4:0] KEY_DIV = 5'd13;
  localparam logic [4:0] KEY_EQ  = 5'd14;
  localparam logic [4:0] KEY_CLR = 5'd15;

  function automatic calc_op_t key_to_op(input logic [4:0] code);
    case (code)
      KEY_ADD: return OpAdd;
      KEY_SUB: return OpSub;
      KEY_MUL: return OpMul;
      KEY_DIV: return OpDiv;
      default: return OpNone;
    endcase
  endfunction

endpackage

// File: rtl/calc_if.sv
// Keypad event input and display-status output bundle of the calculator engine.
interface calc_if #(
    parameter int unsigned WIDTH = 32
);
    logic             key_valid;
    logic [4:0]       key_code;
    logic [WIDTH-1:0] disp_val;
    logic             disp_neg;
    logic [2:0]       op_sel;
    logic             busy;
    logic             err;
    logic [2:0]       state_o;

    modport master (
        output key_valid, key_code,
        input  disp_val, disp_neg, op_sel, busy, err, state_o
    );

    modport slave (
        input  key_valid, key_code,
        output disp_val, disp_neg, op_sel, busy, err, state_o
    );
endinterface

// File: rtl/calc_seq_alu.sv
// Sequential arithmetic unit: single-cycle add/sub, iterative multiply and (with CALC_DIV_EN)
// restoring divide; start and done are one-cycle pulses, clr_i abandons any iteration.
module calc_seq_alu
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             hz100,
    input  logic             reset,
    input  logic             start_i,
    input  logic             clr_i,
    input  calc_op_t         op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             neg_o,
    output logic             ovf_o
);
    localparam int unsigned CntW = $clog2(WIDTH);

    // {partial product, remaining multiplier} consumed LSB first.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   mcand);
        logic [WIDTH:0] sum;
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        return {sum, acc[WIDTH-1:1]};
    endfunction

`ifdef CALC_DIV_EN
    // {remainder, dividend/quotient}; quotient bits shift in from the right.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   dvsr);
        logic [WIDTH:0] sh;
        logic [WIDTH:0] trial;
        sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial = sh - {1'b0, dvsr};
        if (sh >= {1'b0, dvsr}) return {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else                    return {sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    endfunction
`endif

    calc_op_t           op_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opnd_q;
    logic [CntW-1:0]    cnt_q;
    logic               run_q;
    logic               done_q;
    logic [WIDTH-1:0]   res_q;
    logic               neg_q;
    logic               ovf_q;

    always_comb begin
        acc_step = mul_step(acc_q, opnd_q);
`ifdef CALC_DIV_EN
        if (op_q == OpDiv) acc_step = div_step(acc_q, opnd_q);
`endif
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            op_q   <= OpNone;
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
            res_q  <= '0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (clr_i) begin
            op_q   <= OpNone;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
            res_q  <= '0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                op_q  <= op_i;
                neg_q <= 1'b0;
                ovf_q <= 1'b0;
                unique case (op_i)
                    OpAdd: begin
                        {ovf_q, res_q} <= {1'b0, a_i} + {1'b0, b_i};
                        done_q         <= 1'b1;
                    end
                    OpSub: begin
                        if (a_i >= b_i) begin
                            res_q <= a_i - b_i;
                        end else begin
                            res_q <= b_i - a_i;
                            neg_q <= 1'b1;
                        end
                        done_q <= 1'b1;
                    end
                    // First iteration happens on the start edge itself.
                    OpMul: begin
                        acc_q  <= mul_step({{WIDTH{1'b0}}, b_i}, a_i);
                        opnd_q <= a_i;
                        cnt_q  <= CntW'(1);
                        run_q  <= 1'b1;
                    end
`ifdef CALC_DIV_EN
                    OpDiv: begin
                        if (b_i == '0) begin
                            res_q  <= '0;
                            ovf_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            acc_q  <= div_step({{WIDTH{1'b0}}, a_i}, b_i);
                            opnd_q <= b_i;
                            cnt_q  <= CntW'(1);
                            run_q  <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        res_q  <= '0;
                        done_q <= 1'b1;
                    end
                endcase
            end else if (run_q) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                    res_q  <= acc_step[WIDTH-1:0];
                    ovf_q  <= (op_q == OpMul) && (|acc_step[2*WIDTH-1:WIDTH]);
                end
            end
        end
    end

    assign done_o   = done_q;
    assign result_o = res_q;
    assign neg_o    = neg_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/calc_engine.sv
// Keypad calculator sequencer: operand entry, operator latching, result chaining and error hold.
// Define CALC_DIV_EN to accept the DIV key and build the divider.
module calc_engine
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MAX_DIGITS = 8
) (
    input  logic  hz100,
    input  logic  reset,
    calc_if.slave bus
);
    localparam int unsigned DigW = $clog2(MAX_DIGITS + 1);

    calc_state_t      state_q;
    calc_op_t         op_sel_q;
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;
    logic [DigW-1:0]  cnt1_q;
    logic [DigW-1:0]  cnt2_q;
    logic [WIDTH-1:0] disp_val_q;
    logic             disp_neg_q;
    logic             busy_q;
    logic             err_q;
    logic             start_q;

    logic             is_digit;
    logic             is_op;
    logic             is_eq;
    logic             is_clr;
    calc_op_t         key_op;
    logic [WIDTH-1:0] digit;
    logic [WIDTH-1:0] acc1;
    logic [WIDTH-1:0] acc2;

    logic             alu_done;
    logic [WIDTH-1:0] alu_res;
    logic             alu_neg;
    logic             alu_ovf;

    assign is_digit = bus.key_valid && (bus.key_code < 5'd10);
    assign is_eq    = bus.key_valid && (bus.key_code == KEY_EQ);
    assign is_clr   = bus.key_valid && (bus.key_code == KEY_CLR);
`ifdef CALC_DIV_EN
    assign is_op    = bus.key_valid && (bus.key_code >= KEY_ADD) && (bus.key_code <= KEY_DIV);
`else
    assign is_op    = bus.key_valid && (bus.key_code >= KEY_ADD) && (bus.key_code <= KEY_MUL);
`endif
    assign key_op   = key_to_op(bus.key_code);
    assign digit    = WIDTH'(bus.key_code[3:0]);
    // op*10 + d; the digit limit keeps this from wrapping.
    assign acc1     = (op1_q << 3) + (op1_q << 1) + digit;
    assign acc2     = (op2_q << 3) + (op2_q << 1) + digit;

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            state_q    <= StEntry1;
            op_sel_q   <= OpNone;
            op1_q      <= '0;
            op2_q      <= '0;
            cnt1_q     <= '0;
            cnt2_q     <= '0;
            disp_val_q <= '0;
            disp_neg_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (is_clr) begin
                state_q    <= StEntry1;
                op_sel_q   <= OpNone;
                op1_q      <= '0;
                op2_q      <= '0;
                cnt1_q     <= '0;
                cnt2_q     <= '0;
                disp_val_q <= '0;
                disp_neg_q <= 1'b0;
                busy_q     <= 1'b0;
                err_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    StEntry1: begin
                        if (is_digit) begin
                            if (cnt1_q < DigW'(MAX_DIGITS)) begin
                                op1_q      <= acc1;
                                cnt1_q     <= cnt1_q + DigW'(1);
                                disp_val_q <= acc1;
                            end
                        end else if (is_op) begin
                            op_sel_q <= key_op;
                            op2_q    <= '0;
                            cnt2_q   <= '0;
                            state_q  <= StEntry2;
                        end
                    end
                    StEntry2: begin
                        if (is_digit) begin
                            if (cnt2_q < DigW'(MAX_DIGITS)) begin
                                op2_q      <= acc2;
                                cnt2_q     <= cnt2_q + DigW'(1);
                                disp_val_q <= acc2;
                            end
                        end else if (is_op) begin
                            if (cnt2_q == '0) op_sel_q <= key_op;
                        end else if (is_eq) begin
                            state_q <= StExec;
                            start_q <= 1'b1;
                        end
                    end
                    StExec: begin
                        if (alu_done) begin
                            busy_q <= 1'b0;
                            if (alu_ovf) begin
                                state_q    <= StError;
                                err_q      <= 1'b1;
                                disp_val_q <= '0;
                                disp_neg_q <= 1'b0;
                            end else begin
                                state_q    <= StResult;
                                disp_val_q <= alu_res;
                                disp_neg_q <= alu_neg;
                            end
                        end else begin
                            busy_q <= 1'b1;
                        end
                    end
                    StResult: begin
                        if (is_digit) begin
                            op1_q      <= digit;
                            cnt1_q     <= DigW'(1);
                            op2_q      <= '0;
                            cnt2_q     <= '0;
                            op_sel_q   <= OpNone;
                            disp_val_q <= digit;
                            disp_neg_q <= 1'b0;
                            state_q    <= StEntry1;
                        end else if (is_op && !disp_neg_q) begin
                            op1_q    <= disp_val_q;
                            op2_q    <= '0;
                            cnt2_q   <= '0;
                            op_sel_q <= key_op;
                            state_q  <= StEntry2;
                        end
                    end
                    StError: ;
                    default: state_q <= StEntry1;
                endcase
            end
        end
    end

    calc_seq_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .hz100   (hz100),
        .reset   (reset),
        .start_i (start_q),
        .clr_i   (is_clr),
        .op_i    (op_sel_q),
        .a_i     (op1_q),
        .b_i     (op2_q),
        .done_o  (alu_done),
        .result_o(alu_res),
        .neg_o   (alu_neg),
        .ovf_o   (alu_ovf)
    );

    assign bus.disp_val = disp_val_q;
    assign bus.disp_neg = disp_neg_q;
    assign bus.op_sel   = op_sel_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
    assign bus.state_o  = state_q;

endmodule

// File: tb/tb_calc_engine.sv
// Directed bench for calc_engine; EQ results go through an expected-value queue.
// Divide checks are selected by CALC_DIV_EN.
module tb_calc_engine;
    import calc_pkg::*;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [31:0] val;
        logic        neg;
        logic        err;
        logic [2:0]  st;
        logic [7:0]  lat;
    } exp_t;

    logic hz100 = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    calc_if #(.WIDTH(W)) bus ();

    calc_engine #(
        .WIDTH     (W),
        .MAX_DIGITS(8)
    ) u_dut (
        .hz100(hz100),
        .reset(reset),
        .bus  (bus)
    );

    always #5 hz100 = ~hz100;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [4:0] code);
        @(negedge hz100);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge hz100);
        bus.key_valid = 1'b0;
        bus.key_code  = 5'd31;
    endtask

    task automatic key_num(input longint unsigned n);
        string s;
        s = $sformatf("%0d", n);
        for (int i = 0; i < s.len(); i++) press(5'(s[i] - 8'd48));
    endtask

    function automatic exp_t model(input int op, input longint unsigned a, input longint unsigned b);
        exp_t e;
        longint unsigned r;
        e = '0;
        e.lat = 8'd2;
        case (op)
            1: begin r = a + b; e.err = (r > 64'hFFFF_FFFF); e.val = r[31:0]; end
            2: begin
                if (a >= b) e.val = 32'(a - b);
                else begin e.val = 32'(b - a); e.neg = 1'b1; end
            end
            3: begin r = a * b; e.err = (r > 64'hFFFF_FFFF); e.val = r[31:0]; e.lat = 8'(W + 1); end
            default: begin
                if (b == 0) e.err = 1'b1;
                else begin e.val = 32'(a / b); e.lat = 8'(W + 1); end
            end
        endcase
        if (e.err) begin e.val = '0; e.st = 3'd4; end
        else e.st = 3'd3;
        return e;
    endfunction

    // Press EQ, then follow EXEC until RESULT/ERROR; optionally inject a key mid-run.
    task automatic run_eq(input exp_t e, input string tag, input logic inj, input logic [4:0] code);
        exp_t got;
        int   n;
        int   bcnt;
        logic fin;
        sb.push_back(e);
        press(KEY_EQ);
        n = 0; bcnt = 0; fin = 1'b0;
        while (!fin && n < int'(W) + 10) begin
            @(negedge hz100);
            n++;
            if (inj && n == 3) begin bus.key_valid = 1'b1; bus.key_code = code; end
            if (n == 4) bus.key_valid = 1'b0;
            if (bus.busy) bcnt++;
            if (bus.state_o == 3'd3 || bus.state_o == 3'd4) fin = 1'b1;
        end
        bus.key_valid = 1'b0;
        got = sb.pop_front();
        chk({tag, "_finished"}, 64'(fin), 64'd1);
        chk({tag, "_latency"}, 64'(n), 64'(got.lat));
        chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(got.lat) - 64'd1);
        chk({tag, "_val"}, 64'(bus.disp_val), 64'(got.val));
        chk({tag, "_neg"}, 64'(bus.disp_neg), 64'(got.neg));
        chk({tag, "_err"}, 64'(bus.err), 64'(got.err));
        chk({tag, "_state"}, 64'(bus.state_o), 64'(got.st));
    endtask

    initial begin
        int dones;
        int nonidle;
        bus.key_valid = 1'b0;
        bus.key_code  = 5'd31;
        repeat (3) @(negedge hz100);
        reset = 1'b1;
        @(negedge hz100);
        chk("rst_state", 64'(bus.state_o), 64'd0);
        chk("rst_disp", 64'(bus.disp_val), 64'd0);
        chk("rst_neg", 64'(bus.disp_neg), 64'd0);
        chk("rst_op", 64'(bus.op_sel), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);

        // 12 + 34
        key_num(12);
        chk("add_op1_disp", 64'(bus.disp_val), 64'd12);
        press(KEY_ADD);
        chk("add_state_e2", 64'(bus.state_o), 64'd1);
        chk("add_opsel", 64'(bus.op_sel), 64'd1);
        chk("add_disp_op1", 64'(bus.disp_val), 64'd12);
        key_num(34);
        chk("add_op2_disp", 64'(bus.disp_val), 64'd34);
        run_eq(model(1, 12, 34), "add", 1'b0, 5'd0);

        // 7 - 9 gives a negative result; operators must not chain from it
        press(KEY_CLR);
        key_num(7); press(KEY_SUB); key_num(9);
        run_eq(model(2, 7, 9), "sub", 1'b0, 5'd0);
        press(KEY_ADD);
        chk("neg_chain_state", 64'(bus.state_o), 64'd3);
        chk("neg_chain_opsel", 64'(bus.op_sel), 64'd2);
        chk("neg_chain_disp", 64'(bus.disp_val), 64'd2);

        // 6 * 7 with a digit key dropped during EXEC, then chain + 8, then new entry
        press(KEY_CLR);
        key_num(6); press(KEY_MUL); key_num(7);
        run_eq(model(3, 6, 7), "mul", 1'b1, 5'd9);
        press(KEY_ADD);
        chk("chain_state", 64'(bus.state_o), 64'd1);
        chk("chain_opsel", 64'(bus.op_sel), 64'd1);
        chk("chain_disp", 64'(bus.disp_val), 64'd42);
        key_num(8);
        run_eq(model(1, 42, 8), "chain_add", 1'b0, 5'd0);
        press(5'd5);
        chk("new_state", 64'(bus.state_o), 64'd0);
        chk("new_disp", 64'(bus.disp_val), 64'd5);
        chk("new_opsel", 64'(bus.op_sel), 64'd0);

        // multiply overflow latches ERROR until CLR
        press(KEY_CLR);
        key_num(99999); press(KEY_MUL); key_num(99999);
        run_eq(model(3, 99999, 99999), "mul_ovf", 1'b0, 5'd0);
        press(5'd1); press(KEY_ADD); press(KEY_EQ);
        chk("err_hold_state", 64'(bus.state_o), 64'd4);
        chk("err_hold_err", 64'(bus.err), 64'd1);
        chk("err_hold_disp", 64'(bus.disp_val), 64'd0);
        press(KEY_CLR);
        chk("err_clr_state", 64'(bus.state_o), 64'd0);
        chk("err_clr_err", 64'(bus.err), 64'd0);

        // large product, then chained add carries out
        key_num(65535); press(KEY_MUL); key_num(65535);
        run_eq(model(3, 65535, 65535), "mul_big", 1'b0, 5'd0);
        press(KEY_ADD); key_num(99999999);
        run_eq(model(1, 64'd4294836225, 99999999), "add_carry", 1'b0, 5'd0);

        // digit limit, invalid key, operator replacement then lock-in
        press(KEY_CLR);
        for (int d = 1; d <= 9; d++) press(5'(d));
        chk("digit_limit", 64'(bus.disp_val), 64'd12345678);
        press(5'd20);
        chk("invalid_disp", 64'(bus.disp_val), 64'd12345678);
        chk("invalid_state", 64'(bus.state_o), 64'd0);
        press(KEY_ADD); press(KEY_SUB);
        chk("op_replace", 64'(bus.op_sel), 64'd2);
        key_num(5); press(KEY_MUL);
        chk("op_locked", 64'(bus.op_sel), 64'd2);
        chk("op_locked_disp", 64'(bus.disp_val), 64'd5);
        run_eq(model(2, 12345678, 5), "sub_big", 1'b0, 5'd0);

`ifdef CALC_DIV_EN
        press(KEY_CLR);
        key_num(100); press(KEY_DIV);
        chk("div_opsel", 64'(bus.op_sel), 64'd4);
        key_num(7);
        run_eq(model(4, 100, 7), "div", 1'b0, 5'd0);
        press(KEY_CLR);
        key_num(5); press(KEY_DIV); key_num(0);
        run_eq(model(4, 5, 0), "div_zero", 1'b0, 5'd0);
`else
        press(KEY_CLR);
        press(KEY_DIV);
        chk("nodiv_state", 64'(bus.state_o), 64'd0);
        chk("nodiv_opsel", 64'(bus.op_sel), 64'd0);
        key_num(3); press(KEY_DIV);
        chk("nodiv_state2", 64'(bus.state_o), 64'd0);
        chk("nodiv_disp", 64'(bus.disp_val), 64'd3);
        press(KEY_ADD); press(KEY_DIV);
        chk("nodiv_e2_opsel", 64'(bus.op_sel), 64'd1);
`endif

        // CLR a few cycles into a multiply; the abandoned run must stay silent
        press(KEY_CLR);
        key_num(6); press(KEY_MUL); key_num(7); press(KEY_EQ);
        repeat (2) @(negedge hz100);
        press(KEY_CLR);
        chk("abort_state", 64'(bus.state_o), 64'd0);
        chk("abort_disp", 64'(bus.disp_val), 64'd0);
        chk("abort_neg", 64'(bus.disp_neg), 64'd0);
        chk("abort_opsel", 64'(bus.op_sel), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_err", 64'(bus.err), 64'd0);
        dones = 0; nonidle = 0;
        repeat (W + 5) begin
            @(negedge hz100);
            if (u_dut.u_alu.done_o) dones++;
            if (bus.state_o != 3'd0 || bus.busy) nonidle++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        chk("abort_idle", 64'(nonidle), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
